// File: rtl/read_arbiter_pkg.sv
// Shared types and widths for the SRAM read arbiter and its rotating
// first-set picker.
package read_arbiter_pkg;

  localparam int NUM_PORTS = 16;
  localparam int DATA_W    = 64;
  localparam int PRIO_W    = 3;
  localparam int PORT_W    = 4;
  localparam int CREDIT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_START = 2'd2,
    ST_XFER  = 2'd3
  } state_e;

endpackage

// File: rtl/read_arbiter_picker.sv
// Combinational find-first-set over N request bits, scanning upward from a
// rotating pointer and wrapping at N-1.
module wrr_picker #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (W+1)'(k);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (!found_o && req_i[cand[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/read_arbiter.sv
// Read-side arbiter: grants one output port a packet read from shared SRAM,
// issues the read start and steers the returned beat stream to that port.
module read_arbiter
  import read_arbiter_pkg::*;
#(
  parameter int num_of_ports       = NUM_PORTS,
  parameter int arbiter_data_width = DATA_W,
  parameter int priority_width     = PRIO_W,
  parameter int des_port_width     = PORT_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sp0_wrr1,
  input  logic [num_of_ports-1:0]                req,
  input  logic [num_of_ports-1:0]                port_ready,
  input  logic [num_of_ports*priority_width-1:0] pkt_prio_p,
  input  logic [arbiter_data_width-1:0]          rd_data_in,
  input  logic                                   rd_vld_in,
  input  logic                                   rd_sop_in,
  input  logic                                   rd_eop_in,
  output logic                                   rd_start,
  output logic [des_port_width-1:0]              rd_port,
  output logic [priority_width-1:0]              rd_prio,
  output logic [num_of_ports-1:0]                grant,
  output logic                                   busy,
  output logic [arbiter_data_width-1:0]          data_out,
  output logic [num_of_ports-1:0]                out_vld,
  output logic [num_of_ports-1:0]                out_sop,
  output logic [num_of_ports-1:0]                out_eop
);

  logic [num_of_ports-1:0]       eligible;
  logic [priority_width-1:0]     prio_a [num_of_ports];
  logic [priority_width-1:0]     max_prio;
  logic [num_of_ports-1:0]       sp_mask;
  logic [num_of_ports-1:0]       pick_req;
  logic [des_port_width-1:0]     pick_ptr;
  logic [des_port_width-1:0]     win_idx;
  logic                          win_found;
  logic [num_of_ports-1:0]       grant_d;
  logic [des_port_width-1:0]     ptr_inc_d;

  state_e                        state_q;
  logic [des_port_width-1:0]     ptr_q;
  logic [CREDIT_W-1:0]           credit_q [num_of_ports];
  logic                          wrr_pkt_q;
  logic                          rd_start_q;
  logic [des_port_width-1:0]     rd_port_q;
  logic [priority_width-1:0]     rd_prio_q;
  logic [num_of_ports-1:0]       grant_q;
  logic [arbiter_data_width-1:0] data_q;
  logic [num_of_ports-1:0]       out_vld_q;
  logic [num_of_ports-1:0]       out_sop_q;
  logic [num_of_ports-1:0]       out_eop_q;

  assign eligible = req & port_ready;

  for (genvar gi = 0; gi < num_of_ports; gi++) begin : g_port
    assign prio_a[gi]  = pkt_prio_p[gi*priority_width +: priority_width];
    assign sp_mask[gi] = eligible[gi] && (prio_a[gi] == max_prio);
  end

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      if (eligible[i] && (prio_a[i] > max_prio)) max_prio = prio_a[i];
    end
  end

  // SP reuses the picker: only max-priority ports remain, scanned from 0 so
  // ties resolve to the lowest index.
  assign pick_req = sp0_wrr1 ? eligible : sp_mask;
  assign pick_ptr = sp0_wrr1 ? ptr_q : '0;

  wrr_picker #(
    .N (num_of_ports),
    .W (des_port_width)
  ) u_picker (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign grant_d   = {{(num_of_ports-1){1'b0}}, 1'b1} << win_idx;
  assign ptr_inc_d = (rd_port_q == des_port_width'(num_of_ports-1))
                   ? '0 : rd_port_q + des_port_width'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      wrr_pkt_q  <= 1'b0;
      rd_start_q <= 1'b0;
      rd_port_q  <= '0;
      rd_prio_q  <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      out_vld_q  <= '0;
      out_sop_q  <= '0;
      out_eop_q  <= '0;
      for (int i = 0; i < num_of_ports; i++) credit_q[i] <= '0;
    end else begin
      rd_start_q <= 1'b0;
      out_vld_q  <= '0;
      out_sop_q  <= '0;
      out_eop_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|eligible) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (win_found) begin
            grant_q    <= grant_d;
            rd_port_q  <= win_idx;
            rd_prio_q  <= prio_a[win_idx];
            wrr_pkt_q  <= sp0_wrr1;
            rd_start_q <= 1'b1;
            state_q    <= ST_START;
            if (sp0_wrr1 && (credit_q[win_idx] == '0)) begin
              credit_q[win_idx] <= CREDIT_W'(prio_a[win_idx]) + CREDIT_W'(1);
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (rd_vld_in) begin
            data_q    <= rd_data_in;
            out_vld_q <= grant_q;
            out_sop_q <= rd_sop_in ? grant_q : '0;
            out_eop_q <= rd_eop_in ? grant_q : '0;
            if (rd_eop_in) begin
              grant_q <= '0;
              state_q <= ST_IDLE;
              // Last credit used: move past this port; otherwise stay on it.
              if (wrr_pkt_q) begin
                if (credit_q[rd_port_q] == CREDIT_W'(1)) begin
                  credit_q[rd_port_q] <= '0;
                  ptr_q               <= ptr_inc_d;
                end else begin
                  credit_q[rd_port_q] <= credit_q[rd_port_q] - CREDIT_W'(1);
                  ptr_q               <= rd_port_q;
                end
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_start = rd_start_q;
  assign rd_port  = rd_port_q;
  assign rd_prio  = rd_prio_q;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign data_out = data_q;
  assign out_vld  = out_vld_q;
  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;

endmodule
